isn_gen: RTL
============

Name: isn_gen

Overview:
- Upstream producer for the per-flow initial-sequence-number table; drives its single write port.
- On a new-flow request from the connection-setup logic, computes an ISN from a free-running ISN clock plus a per-flow hash.
- Writes the ISN into the table entry for the flow, then returns a completion carrying the flow id and ISN.

Parameters:
- width_p, `SEQ_NUM_WIDTH (32): ISN and hash width.
- els_p, `MAX_FLOW_CNT: number of flow entries.
- addr_w, `BSG_SAFE_CLOG2(els_p): flow id width.
- TICK_DIV_P, 4: cycles per ISN clock increment; must be >= 1.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- new_flow_val  input  1  request valid
- new_flow_id  input  addr_w  flow table index
- new_flow_hash  input  width_p  per-flow hash of the 4-tuple
- new_flow_rdy  output  1  request accepted when val&rdy
- isn_wr_req_val  output  1  write valid to ISN table
- isn_wr_req_addr  output  addr_w  write address
- isn_wr_num  output  width_p  ISN to write
- isn_wr_req_rdy  input  1  table accepts write
- new_flow_done_val  output  1  completion valid
- new_flow_done_id  output  addr_w  completed flow id
- new_flow_done_isn  output  width_p  ISN assigned
- new_flow_done_rdy  input  1  consumer accepts completion

Behaviour:
- Clock and reset: one clock domain. All flops reset asynchronously when rst=0 and release on the first clk edge with rst=1.
- ISN clock: tick_cnt counts 0..TICK_DIV_P-1 every cycle. When tick_cnt==TICK_DIV_P-1, tick_cnt returns to 0 and isn_clk increments by 1, modulo 2^width_p. Both reset to 0. Counting is never stalled by handshakes.
- FSM states, reset to IDLE:
  - IDLE: new_flow_rdy=1. On new_flow_val, latch id, and latch isn = isn_clk + new_flow_hash (mod 2^width_p), using isn_clk's pre-edge value. Go to WR.
  - WR: isn_wr_req_val=1; addr/num come from the latches and hold stable. On isn_wr_req_rdy go to NOTIFY.
  - NOTIFY: new_flow_done_val=1 with the latched id/isn, held stable. On new_flow_done_rdy go to IDLE.
- Handshake: new_flow_rdy is 0 outside IDLE. Minimum latency is request edge k, write edge k+1, done edge k+2; peak throughput is 1 request per 3 cycles.
- No same-cycle bypass from IDLE to NOTIFY. WR never skips even if the write has rdy in the same cycle as the request.
- Reset values: new_flow_rdy=1 (state IDLE); isn_wr_req_val=0, isn_wr_req_addr=0, isn_wr_num=0, new_flow_done_val=0, new_flow_done_id=0, new_flow_done_isn=0.
- Reset mid-operation: the in-flight request is dropped. No write or completion is issued for it, and counters return to 0.
- Back-to-back requests to the same id: each gets its own ISN; the later write overwrites the earlier one.
- The table owns read/write ordering; this block does not track flow liveness.

Optional Feature:
- Macro: ISN_GEN_LFSR_EN.
- Defined: a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, resets to 16'hACE1 and advances every cycle. Next state = {l[0]^l[2]^l[3]^l[5], l[15:1]}. The latched isn = isn_clk + new_flow_hash + zero-extended lfsr (mod 2^width_p).
- Undefined: no LFSR flops; isn = isn_clk + new_flow_hash.

Decomposition:
- Package isn_gen_pkg: FSM state enum (IDLE, WR, NOTIFY); LFSR seed 16'hACE1; tap positions.
- One sub-module, isn_clock. It holds the tick divider, isn_clk and the optional LFSR, and outputs isn_clk and lfsr.

Test Plan:
1. Basic: TICK_DIV_P=4, all rdy=1. Request id=3, hash=32'h1000_0000 when isn_clk=5 -> next cycle write addr=3, num=32'h1000_0005; following cycle done id=3, isn=32'h1000_0005; new_flow_rdy back to 1 after that.
2. Write backpressure: hold isn_wr_req_rdy=0 for 3 cycles -> isn_wr_req_val, addr and num held stable; new_flow_rdy=0; isn_clk still advances; num unchanged.
3. Wrap-around: hash=32'hFFFF_FFFF, isn_clk=2 -> num=32'h0000_0001.
4. Completion backpressure: new_flow_done_rdy=0 for 5 cycles -> done outputs stable, no second write, a new request is not accepted.
5. Reset mid-WR: assert rst=0 while isn_wr_req_val=1 -> all outputs go to reset values immediately; after release, no write for the dropped id, and isn_clk restarts at 0.
6. ISN_GEN_LFSR_EN: request with hash=0 on the first cycle after reset release (isn_clk=0, lfsr=16'hACE1) -> num=32'h0000_ACE1.

Source files
------------

// File: rtl/isn_gen_pkg.sv
// Shared types and constants for the ISN generator: FSM states and LFSR seed/taps.
// The LFSR parts are only used when ISN_GEN_LFSR_EN is defined.
package isn_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR     = 2'd1,
    NOTIFY = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form
  localparam int LFSR_TAP_A = 0;
  localparam int LFSR_TAP_B = 2;
  localparam int LFSR_TAP_C = 3;
  localparam int LFSR_TAP_D = 5;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[LFSR_TAP_A] ^ l[LFSR_TAP_B] ^ l[LFSR_TAP_C] ^ l[LFSR_TAP_D], l[15:1]};
  endfunction

endpackage

// File: rtl/isn_clock.sv
// Free-running ISN clock: divides clk by tick_div_p and counts modulo 2^width_p.
// With ISN_GEN_LFSR_EN defined it also runs a 16-bit LFSR that steps every cycle.
module isn_clock
  import isn_gen_pkg::*;
#(
  parameter int width_p    = 32,
  parameter int tick_div_p = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic [width_p-1:0] isn_clk
`ifdef ISN_GEN_LFSR_EN
  ,
  output logic [15:0]        lfsr
`endif
);

  // A divider of 1 still needs a 1-bit counter that simply stays at 0
  localparam int cnt_w = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
  localparam logic [cnt_w-1:0] tick_last = cnt_w'(tick_div_p - 1);

  logic [cnt_w-1:0]   tick_cnt_reg;
  logic [width_p-1:0] isn_clk_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_reg <= '0;
      isn_clk_reg  <= '0;
    end else if (tick_cnt_reg == tick_last) begin
      tick_cnt_reg <= '0;
      isn_clk_reg  <= isn_clk_reg + width_p'(1);
    end else begin
      tick_cnt_reg <= tick_cnt_reg + cnt_w'(1);
    end
  end

  assign isn_clk = isn_clk_reg;

`ifdef ISN_GEN_LFSR_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign lfsr = lfsr_reg;
`endif

endmodule

// File: rtl/isn_gen.sv
// New-flow ISN generator: latches isn_clk + hash on request, writes it to the ISN table,
// then reports completion. Optional LFSR whitening is enabled by ISN_GEN_LFSR_EN.
module isn_gen
  import isn_gen_pkg::*;
#(
  parameter int width_p    = 32,
  parameter int els_p      = 16,
  parameter int addr_w     = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int TICK_DIV_P = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_flow_val,
  input  logic [addr_w-1:0]  new_flow_id,
  input  logic [width_p-1:0] new_flow_hash,
  output logic               new_flow_rdy,
  output logic               isn_wr_req_val,
  output logic [addr_w-1:0]  isn_wr_req_addr,
  output logic [width_p-1:0] isn_wr_num,
  input  logic               isn_wr_req_rdy,
  output logic               new_flow_done_val,
  output logic [addr_w-1:0]  new_flow_done_id,
  output logic [width_p-1:0] new_flow_done_isn,
  input  logic               new_flow_done_rdy
);

  logic [width_p-1:0] isn_clk;
  logic [width_p-1:0] isn_calc;

`ifdef ISN_GEN_LFSR_EN
  logic [15:0] lfsr;

  isn_clock #(
    .width_p    (width_p),
    .tick_div_p (TICK_DIV_P)
  ) u_isn_clock (
    .clk     (clk),
    .rst     (rst),
    .isn_clk (isn_clk),
    .lfsr    (lfsr)
  );

  assign isn_calc = isn_clk + new_flow_hash + width_p'(lfsr);
`else
  isn_clock #(
    .width_p    (width_p),
    .tick_div_p (TICK_DIV_P)
  ) u_isn_clock (
    .clk     (clk),
    .rst     (rst),
    .isn_clk (isn_clk)
  );

  assign isn_calc = isn_clk + new_flow_hash;
`endif

  state_e             state_reg, state_next;
  logic [addr_w-1:0]  id_reg, id_next;
  logic [width_p-1:0] isn_reg, isn_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      isn_reg   <= '0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
      isn_reg   <= isn_next;
    end
  end

  // One request in flight at a time; WR and NOTIFY each take at least one cycle
  always_comb begin
    state_next        = state_reg;
    id_next           = id_reg;
    isn_next          = isn_reg;
    new_flow_rdy      = 1'b0;
    isn_wr_req_val    = 1'b0;
    new_flow_done_val = 1'b0;
    case (state_reg)
      IDLE: begin
        new_flow_rdy = 1'b1;
        if (new_flow_val) begin
          id_next    = new_flow_id;
          isn_next   = isn_calc;
          state_next = WR;
        end
      end
      WR: begin
        isn_wr_req_val = 1'b1;
        if (isn_wr_req_rdy) begin
          state_next = NOTIFY;
        end
      end
      NOTIFY: begin
        new_flow_done_val = 1'b1;
        if (new_flow_done_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latched request drives both the write and the completion payloads
  assign isn_wr_req_addr   = id_reg;
  assign isn_wr_num        = isn_reg;
  assign new_flow_done_id  = id_reg;
  assign new_flow_done_isn = isn_reg;

endmodule
